// File: rtl/cdc_dev_pkg.sv
// Shared types and helpers for the USB_CDC device-side byte routing blocks.
// rr_next is width-agnostic so both the IN arbiter and a future OUT router can use it.
package cdc_dev_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int BYTE_W  = 8;
  localparam int MAX_SRC = 8;
  localparam int IDX_W   = 3;

  // First set bit of valid_vec scanning last+1, last+2, ... modulo n; 0 when none.
  function automatic int rr_next(input int last, input logic [MAX_SRC-1:0] valid_vec,
                                 input int n);
    int idx;
    int j;
    logic hit;
    idx = 0;
    hit = 1'b0;
    for (int i = 1; i <= MAX_SRC; i++) begin
      j = (last + i) % n;
      if (!hit && (i <= n) && valid_vec[j[IDX_W-1:0]]) begin
        idx = j;
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: lowest-distance requester after last_i.
module rr_picker
  import cdc_dev_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  assign found_o = |req_i;
  assign idx_o   = IW'(rr_next(int'(last_i), MAX_SRC'(req_i), N));

endmodule

// File: rtl/cdc_in_arbiter.sv
// Round-robin, burst-locked arbiter sharing the USB_CDC IN byte channel among NUM_SRC
// producers, with a single registered output stage.
module cdc_in_arbiter
  import cdc_dev_pkg::*;
#(
  parameter  int NUM_SRC   = 2,
  parameter  int MAX_BURST = 8,
  localparam int GW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [BYTE_W*NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  output logic [BYTE_W-1:0]         in_data_o,
  output logic                      in_valid_o,
  input  logic                      in_ready_i,
  input  logic                      usb_configured_i,
  output logic [GW-1:0]             grant_o,
  output logic                      busy_o
);

  state_e            state_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     last_grant_q;
  logic [CW-1:0]     burst_cnt_q;
  logic [CW-1:0]     burst_cnt_d;
  logic              out_valid_q;
  logic [BYTE_W-1:0] out_data_q;

  logic              free;
  logic              cur_valid;
  logic [BYTE_W-1:0] cur_data;
  logic              xfer;
  logic              last_beat;
  logic              release_grant;
  logic              pick_found;
  logic [GW-1:0]     pick_idx;

  rr_picker #(
    .N  (NUM_SRC),
    .IW (GW)
  ) u_picker (
    .req_i   (src_valid_i),
    .last_i  (last_grant_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // The output register can take a byte if it is empty or being drained this cycle.
  assign free      = ~out_valid_q | in_ready_i;
  assign cur_valid = src_valid_i[grant_q];
  assign cur_data  = src_data_i[grant_q*BYTE_W +: BYTE_W];
  assign xfer      = (state_q == GRANT) & free & usb_configured_i & cur_valid;
  assign last_beat = (burst_cnt_q == CW'(MAX_BURST - 1));
  assign burst_cnt_d = burst_cnt_q + 1'b1;

  assign release_grant = ~usb_configured_i | (xfer & last_beat) | (free & ~cur_valid);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
    assign src_ready_o[gi] = (state_q == GRANT) & (grant_q == GW'(gi)) & free & usb_configured_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      // A host drop discards any byte still waiting in the output stage.
      if (!usb_configured_i) begin
        out_valid_q <= 1'b0;
      end else if (xfer) begin
        out_data_q  <= cur_data;
        out_valid_q <= 1'b1;
      end else if (in_ready_i) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (usb_configured_i && pick_found) begin
            grant_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            burst_cnt_q <= burst_cnt_d;
          end
          if (release_grant) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_data_o  = out_data_q;
  assign in_valid_o = out_valid_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q == GRANT);

endmodule
